// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit blocks.
//   uart_state_t     - line-state encoding common to uart_rx and uart_tx
//   DATA_W           - serial character width (8N1 framing)
//   CLKS_PER_BIT_DEF - default baud divider, matches the baud configuration
//   CNT_W            - width of the per-bit clock counter (dividers up to 1023)
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int CNT_W            = 10;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input plus received-byte outputs of the UART receiver.
//   i_rx        - serial line (driven by the pad / line side)
//   o_data      - last good byte
//   o_valid     - one-cycle strobe, o_data valid in the same cycle
//   o_frame_err - one-cycle strobe, stop bit sampled low
//   o_busy      - receiver is not idle
// master: the receiver itself; slave: the consumer / line driver.
interface uart_rx_if;
    import uart_pkg::*;

    logic              i_rx;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_frame_err;
    logic              o_busy;

    modport master (input i_rx, output o_data, o_valid, o_frame_err, o_busy);
    modport slave  (output i_rx, input o_data, o_valid, o_frame_err, o_busy);

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous single-bit input.
//   clk   - destination clock
//   reset - asynchronous, active-low; both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronised output, two clk cycles of latency
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - uart_rx_if.master: i_rx in; o_data, o_valid, o_frame_err, o_busy out
// The start bit is re-checked at mid-bit, after which every sample lands one
// full bit period later, i.e. at the centre of each data bit and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_if.master     bus
);

    localparam int               HALF_BIT  = CLKS_PER_BIT / 2;
    localparam int               IDX_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    logic              rx_s;
    uart_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              ferr_q;
    logic              busy_q;

    // Idle line is high, so the synchroniser resets to 1 to avoid a false start.
    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.i_rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        if (rx_s) begin
                            // Low pulse shorter than half a bit: treat as noise.
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        // LSB arrives first, so shifting right leaves it in [0].
                        shreg   <= {rx_s, shreg[DATA_W-1:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold here until the line recovers so a break is not
                    // mistaken for a new start bit.
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_frame_err = ferr_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT=16.
// Outputs are sampled on the falling edge; cyc holds the index of the most
// recent rising edge, so a pulse registered at edge N is seen with cyc == N.
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int          vq_cyc[$];
    logic [7:0]  vq_dat[$];
    int          fq_cyc[$];
    int          busy_run = 0;
    int          busy_max = 0;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse recorder and busy-run tracker.
    always @(negedge clk) begin
        if (bus.o_valid) begin
            vq_cyc.push_back(cyc);
            vq_dat.push_back(bus.o_data);
        end
        if (bus.o_frame_err)
            fq_cyc.push_back(cyc);
        if (bus.o_valid || bus.o_frame_err)
            chk("excl", {31'b0, bus.o_valid & bus.o_frame_err}, 32'd0);
        if (bus.o_busy) begin
            busy_run++;
            if (busy_run > busy_max) busy_max = busy_run;
        end else begin
            busy_run = 0;
        end
    end

    task automatic clr();
        vq_cyc.delete();
        vq_dat.delete();
        fq_cyc.delete();
        busy_max = 0;
    endtask

    // Called on a falling edge; t0 is the next rising edge (first sample of start).
    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        logic [9:0] f;
        f  = {stop, b, 1'b0};
        t0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            bus.i_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    initial begin
        int t0, t1;
        logic [9:0] f;
        bus.i_rx = 1'b1;

        // 1: reset held with the line toggling
        for (int i = 0; i < 12; i++) begin
            bus.i_rx = i[0];
            @(negedge clk);
        end
        chk("rst_valid", {31'b0, bus.o_valid}, 32'd0);
        chk("rst_ferr",  {31'b0, bus.o_frame_err}, 32'd0);
        chk("rst_busy",  {31'b0, bus.o_busy}, 32'd0);
        chk("rst_data",  {24'b0, bus.o_data}, 32'h00);
        bus.i_rx = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_nv",   vq_cyc.size(), 32'd0);
        chk("idle_nf",   fq_cyc.size(), 32'd0);
        chk("idle_busy", {31'b0, bus.o_busy}, 32'd0);

        // 2: single good frame 8'hA5
        clr();
        send_frame(8'hA5, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("a5_nv", vq_cyc.size(), 32'd1);
        chk("a5_nf", fq_cyc.size(), 32'd0);
        if (vq_cyc.size() > 0) begin
            chk("a5_cyc", vq_cyc[0], t0 + 154);
            chk("a5_dat", {24'b0, vq_dat[0]}, 32'hA5);
        end
        chk("a5_hold", {24'b0, bus.o_data}, 32'hA5);

        // 3: 5-cycle low glitch
        clr();
        bus.i_rx = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("gl_busy", busy_max, 32'd8);
        chk("gl_nv",   vq_cyc.size(), 32'd0);
        chk("gl_nf",   fq_cyc.size(), 32'd0);

        // 4: framing error followed by a long break
        clr();
        send_frame(8'h3C, 1'b0, t0);
        repeat (40 * CPB) @(negedge clk);
        chk("brk_busy", {31'b0, bus.o_busy}, 32'd1);
        chk("brk_nf",   fq_cyc.size(), 32'd1);
        if (fq_cyc.size() > 0)
            chk("brk_cyc", fq_cyc[0], t0 + 154);
        bus.i_rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("brk_idle", {31'b0, bus.o_busy}, 32'd0);
        chk("brk_nv",   vq_cyc.size(), 32'd0);
        chk("brk_data", {24'b0, bus.o_data}, 32'hA5);
        send_frame(8'h5A, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("post_nv", vq_cyc.size(), 32'd1);
        chk("post_nf", fq_cyc.size(), 32'd1);
        chk("post_dat", {24'b0, bus.o_data}, 32'h5A);

        // 5: back-to-back 8'h00 then 8'hFF
        clr();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        repeat (20) @(negedge clk);
        chk("b2b_nv", vq_cyc.size(), 32'd2);
        if (vq_cyc.size() == 2) begin
            chk("b2b_c0",  vq_cyc[0], t0 + 154);
            chk("b2b_gap", vq_cyc[1] - vq_cyc[0], 32'd160);
            chk("b2b_d0",  {24'b0, vq_dat[0]}, 32'h00);
            chk("b2b_d1",  {24'b0, vq_dat[1]}, 32'hFF);
        end

        // 6: reset during data bit 4 of 8'h81, then 8'h42
        clr();
        f = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.i_rx = f[i];
            repeat (CPB) @(negedge clk);
        end
        bus.i_rx = f[5];
        repeat (CPB / 2) @(negedge clk);
        chk("mid_busy", {31'b0, bus.o_busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("ar_busy", {31'b0, bus.o_busy}, 32'd0);
        chk("ar_data", {24'b0, bus.o_data}, 32'h00);
        bus.i_rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("ar_nv", vq_cyc.size(), 32'd0);
        chk("ar_nf", fq_cyc.size(), 32'd0);
        send_frame(8'h42, 1'b1, t0);
        repeat (20) @(negedge clk);
        chk("r42_nv", vq_cyc.size(), 32'd1);
        if (vq_cyc.size() > 0) begin
            chk("r42_cyc", vq_cyc[0], t0 + 154);
            chk("r42_dat", {24'b0, vq_dat[0]}, 32'h42);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
